// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port round-robin arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

    localparam int unsigned MAX_REQ = 8;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } pick_t;

    function automatic int unsigned ARB_PTR_W(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Rotate req so ptr lands at position 0, take the lowest set bit, rotate the index back.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [2:0]         ptr,
                                      input int unsigned        n);
        logic [MAX_REQ-1:0] rot;
        int unsigned        j;
        pick_t              p;
        rot = '0;
        p   = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                j      = (32'(ptr) + k) % n;
                rot[k] = req[3'(j)];
            end
        end
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (rot[k] && !p.valid) begin
                p.valid = 1'b1;
                p.idx   = 3'((32'(ptr) + k) % n);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_pick.sv
// Combinational round-robin priority pick starting at ptr.
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned PW    = ARB_PTR_W(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    idx,
    output logic             valid
);

    logic [MAX_REQ-1:0] req_ext;
    pick_t              pick;

    always_comb begin
        req_ext              = '0;
        req_ext[N_REQ-1:0]   = req;
        pick                 = rr_pick(req_ext, 3'(ptr), N_REQ);
    end

    assign idx   = PW'(pick.idx);
    assign valid = pick.valid;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers.
// Optional burst ownership (IDLE/OWN lock) is built when FIFO_ARB_BURST_EN is defined.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    input  logic                      fifo_full,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_din,
    output logic [$clog2(N_REQ)-1:0]  owner,
    output logic                      busy
);

    localparam int unsigned PW = ARB_PTR_W(N_REQ);

    logic [PW-1:0] ptr;
    logic [PW-1:0] pick_idx;
    logic          pick_valid;
    logic [PW-1:0] cand;
    logic          cand_valid;
    logic          accept;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] x);
        return (32'(x) == N_REQ - 1) ? '0 : x + 1'b1;
    endfunction

    rr_priority_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef FIFO_ARB_BURST_EN
    localparam logic [0:0] ST_IDLE    = ARB_IDLE;
    localparam logic [0:0] ST_OWN     = ARB_OWN;
    localparam logic [3:0] BURST_LAST = 4'(BURST_LEN);

    logic [0:0] state;
    logic [3:0] beat_cnt;

    always_comb begin
        cand       = pick_idx;
        cand_valid = pick_valid;
        if (state == ST_OWN) begin
            cand       = owner;
            cand_valid = req[owner];
        end
    end

    assign busy = (state == ST_OWN);
`else
    always_comb begin
        cand       = pick_idx;
        cand_valid = pick_valid;
    end

    assign busy = 1'b0;
`endif

    assign accept  = ~rst & ~fifo_full & cand_valid;
    assign fifo_wr = accept;

    always_comb begin
        ack      = '0;
        fifo_din = '0;
        if (accept) begin
            ack[cand] = 1'b1;
            fifo_din  = req_data[32'(cand)*DATA_W +: DATA_W];
        end
    end

`ifdef FIFO_ARB_BURST_EN
    // A full FIFO freezes everything, so an OWN burst survives the stall intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            owner    <= '0;
            state    <= ST_IDLE;
            beat_cnt <= '0;
        end else if (!fifo_full) begin
            if (state == ST_IDLE) begin
                if (accept) begin
                    owner <= cand;
                    if (BURST_LEN > 1) begin
                        beat_cnt <= 4'd1;
                        state    <= ST_OWN;
                    end else begin
                        ptr <= wrap_inc(cand);
                    end
                end
            end else if (accept) begin
                if (beat_cnt + 4'd1 == BURST_LAST) begin
                    ptr      <= wrap_inc(owner);
                    state    <= ST_IDLE;
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + 4'd1;
                end
            end else begin
                ptr      <= wrap_inc(owner);
                state    <= ST_IDLE;
                beat_cnt <= '0;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            owner <= '0;
        end else if (accept) begin
            owner <= cand;
            ptr   <= wrap_inc(cand);
        end
    end
`endif

endmodule
